// File: rtl/bool_share_gen.sv
// bool_share_gen: splits one unmasked word into N_SHARES Boolean shares.
// Shares 0..N-2 are fresh random words. The last share is the input XORed
// with all of them, so the XOR of every share gives back the input.
// Only acc ever holds unmasked data, and it is wiped once the last share
// has been formed.
module bool_share_gen #(
   parameter int K_WIDTH   = 32,
   parameter int N_SHARES  = 3,
   parameter int MASKWIDTH = K_WIDTH*N_SHARES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic                 dvld,
   output logic                 drdy,
   input  logic [K_WIDTH-1:0]   i_x,
   input  logic [K_WIDTH-1:0]   rnd,
   input  logic                 rnd_vld,
   output logic                 rnd_rdy,
   output logic [MASKWIDTH-1:0] o_x,
   output logic                 ovld,
   input  logic                 ordy
);

   localparam int CW = $clog2(N_SHARES);
   localparam logic [CW-1:0] LAST = CW'(N_SHARES-2);

   typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;

   state_t                           state_q, state_d;
   logic [K_WIDTH-1:0]               acc_q, acc_d;
   logic [CW-1:0]                    cnt_q, cnt_d;
   logic [N_SHARES-1:0][K_WIDTH-1:0] share_q, share_d;

   logic in_xfer, rnd_xfer, out_xfer;

   // drdy and rnd_rdy already include ena, so a low ena blocks every transfer
   // and, with it, every state change.
   assign in_xfer  = dvld & drdy;
   assign rnd_xfer = rnd_vld & rnd_rdy;
   assign out_xfer = ovld & ordy & ena;

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic. The last share moves the FSM to DONE. Leaving DONE
   // always returns to IDLE first, which creates the one-cycle bubble.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_xfer) state_d = SPLIT;
         SPLIT:   if (rnd_xfer && cnt_q == LAST) state_d = DONE;
         DONE:    if (out_xfer) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decodes. o_x shows shares only in DONE, so partial shares are never visible.
   always_comb begin
      drdy    = ena && (state_q == IDLE);
      rnd_rdy = ena && (state_q == SPLIT);
      ovld    = (state_q == DONE);
      o_x     = '0;
      if (state_q == DONE) o_x = share_q;
   end

   // Datapath next state: absorb one random word into acc per cycle, and
   // record that word as the next share.
   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      share_d = share_q;
      case (state_q)
         IDLE: begin
            if (in_xfer) begin
               acc_d = i_x;
               cnt_d = '0;
            end
         end
         SPLIT: begin
            if (rnd_xfer) begin
               for (int i = 0; i < N_SHARES-1; i++)
                  if (cnt_q == CW'(i)) share_d[i] = rnd;
               if (cnt_q == LAST) begin
                  share_d[N_SHARES-1] = acc_q ^ rnd;
                  acc_d               = '0;
               end else begin
                  acc_d = acc_q ^ rnd;
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         DONE: begin
            if (out_xfer) share_d = '0;
         end
         default: ;
      endcase
   end

   // Datapath registers. Reset discards any partial split.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         share_q <= '0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         share_q <= share_d;
      end
   end

endmodule

// File: tb/tb_bool_share_gen.sv
// Bench for bool_share_gen. The directed vectors and corner sequences run on
// an N=3 instance. A randomized round trip runs on N=3 and N=5 instances
// against a transaction-level model.
module tb_bool_share_gen;

   logic clk = 1'b0;
   logic rst, ena;

   logic        dvld3, drdy3, rnd_vld3, rnd_rdy3, ovld3, ordy3;
   logic [31:0] ix3, rnd3;
   logic [95:0] ox3;

   logic         dvld5, drdy5, rnd_vld5, rnd_rdy5, ovld5, ordy5;
   logic [31:0]  ix5, rnd5;
   logic [159:0] ox5;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bool_share_gen #(.K_WIDTH(32), .N_SHARES(3)) u3 (
      .clk(clk), .rst(rst), .ena(ena), .dvld(dvld3), .drdy(drdy3), .i_x(ix3),
      .rnd(rnd3), .rnd_vld(rnd_vld3), .rnd_rdy(rnd_rdy3), .o_x(ox3),
      .ovld(ovld3), .ordy(ordy3));

   bool_share_gen #(.K_WIDTH(32), .N_SHARES(5)) u5 (
      .clk(clk), .rst(rst), .ena(ena), .dvld(dvld5), .drdy(drdy5), .i_x(ix5),
      .rnd(rnd5), .rnd_vld(rnd_vld5), .rnd_rdy(rnd_rdy5), .o_x(ox5),
      .ovld(ovld5), .ordy(ordy5));

   typedef struct {
      logic [31:0] x, r0, r1;
      logic [95:0] exp;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Full-XOR unmasker: XOR of the n packed 32-bit shares.
   function automatic logic [31:0] unmask(input logic [159:0] bus, input int n);
      logic [31:0] r = '0;
      for (int i = 0; i < n; i++) r ^= bus[i*32 +: 32];
      return r;
   endfunction

   // One complete split on the N=3 instance, with rnd_vld and ordy high.
   // `stall` idle cycles are inserted between the two random words.
   task automatic run_op(input logic [31:0] x, r0, r1, input int stall,
                         input logic [95:0] exp, input string nm);
      dvld3 = 1'b1; ix3 = x; rnd_vld3 = 1'b0; ordy3 = 1'b1;
      chk({nm, " drdy c0"}, 160'(drdy3), 160'(1));
      tick();
      dvld3 = 1'b0; rnd3 = r0; rnd_vld3 = 1'b1;
      chk({nm, " rnd_rdy c1"}, 160'(rnd_rdy3), 160'(1));
      tick();
      for (int s = 0; s < stall; s++) begin
         rnd_vld3 = 1'b0;
         tick();
         chk({nm, " rnd_rdy stall"}, 160'(rnd_rdy3), 160'(1));
      end
      rnd3 = r1; rnd_vld3 = 1'b1;
      chk({nm, " ovld early"}, 160'(ovld3), 160'(0));
      tick();
      rnd_vld3 = 1'b0;
      chk({nm, " ovld"}, 160'(ovld3), 160'(1));
      chk({nm, " o_x"}, 160'(ox3), 160'(exp));
      tick();
      chk({nm, " ovld after"}, 160'(ovld3), 160'(0));
      chk({nm, " drdy after"}, 160'(drdy3), 160'(1));
      chk({nm, " o_x after"}, 160'(ox3), 160'(0));
   endtask

   // Transaction-level model state for the random run: phase 0 = waiting for
   // a word, 1 = collecting random words, 2 = shares presented.
   int          mph[2], mk[2], ndone[2];
   logic [31:0] mx[2];
   logic [31:0] mr[2][16];

   // Expected bus: random words in order, then the input XORed with all of them.
   function automatic logic [159:0] model_bus(input int d, input int n);
      logic [159:0] b = '0;
      logic [31:0]  last = mx[d];
      for (int i = 0; i < n-1; i++) begin
         b[i*32 +: 32] = mr[d][i];
         last ^= mr[d][i];
      end
      b[(n-1)*32 +: 32] = last;
      return b;
   endfunction

   vec_t tbl[5];

   initial begin
      tbl[0] = '{32'hDEADBEEF, 32'h12345678, 32'h0F0F0F0F, 96'hC396E798_0F0F0F0F_12345678};
      tbl[1] = '{32'h00000000, 32'h00000000, 32'h00000000, 96'h0};
      tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 96'h00000000_00000000_FFFFFFFF};
      tbl[3] = '{32'h00000001, 32'h80000000, 32'h00000003, 96'h80000002_00000003_80000000};
      tbl[4] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 96'h00000000_FFFFFFFF_5A5A5A5A};

      rst = 1'b1; ena = 1'b1;
      dvld3 = 0; rnd_vld3 = 0; ordy3 = 1; ix3 = '0; rnd3 = '0;
      dvld5 = 0; rnd_vld5 = 0; ordy5 = 1; ix5 = '0; rnd5 = '0;
      tick(); tick();
      rst = 1'b0;
      chk("reset drdy", 160'(drdy3), 160'(1));
      chk("reset rnd_rdy", 160'(rnd_rdy3), 160'(0));
      chk("reset ovld", 160'(ovld3), 160'(0));
      chk("reset o_x", 160'(ox3), 160'(0));

      // Table-driven splits, back to back
      for (int v = 0; v < 5; v++)
         run_op(tbl[v].x, tbl[v].r0, tbl[v].r1, 0, tbl[v].exp, $sformatf("vec%0d", v));

      // Two-cycle rnd stall: same result, ovld two cycles later
      run_op(32'hDEADBEEF, 32'h12345678, 32'h0F0F0F0F, 2,
             96'hC396E798_0F0F0F0F_12345678, "stall");

      // Backpressure in DONE, with a competing input word offered
      dvld3 = 1; ix3 = 32'hDEADBEEF; ordy3 = 0;
      tick();
      dvld3 = 0; rnd3 = 32'h12345678; rnd_vld3 = 1;
      tick();
      rnd3 = 32'h0F0F0F0F;
      tick();
      rnd_vld3 = 0; dvld3 = 1; ix3 = 32'h00000000;
      for (int c = 0; c < 4; c++) begin
         chk("bp ovld", 160'(ovld3), 160'(1));
         chk("bp o_x held", 160'(ox3), 160'(96'hC396E798_0F0F0F0F_12345678));
         chk("bp drdy", 160'(drdy3), 160'(0));
         tick();
      end
      ordy3 = 1;
      chk("bp o_x at release", 160'(ox3), 160'(96'hC396E798_0F0F0F0F_12345678));
      tick();
      chk("bp o_x cleared", 160'(ox3), 160'(0));
      chk("bp ovld cleared", 160'(ovld3), 160'(0));
      chk("bp drdy bubble", 160'(drdy3), 160'(1));
      tick();
      dvld3 = 0;
      chk("bp captured", 160'(rnd_rdy3), 160'(1));
      chk("bp drdy busy", 160'(drdy3), 160'(0));
      rnd3 = 32'h12345678; rnd_vld3 = 1;
      tick();
      rnd3 = 32'h0F0F0F0F;
      tick();
      rnd_vld3 = 0;
      chk("bp second o_x", 160'(ox3), 160'(96'h1D3B5977_0F0F0F0F_12345678));
      tick();

      // ena low for three cycles mid-split
      dvld3 = 1; ix3 = 32'hDEADBEEF;
      tick();
      dvld3 = 0; rnd3 = 32'h12345678; rnd_vld3 = 1;
      tick();
      ena = 0; rnd3 = 32'hFFFF0000;
      #1;
      for (int c = 0; c < 3; c++) begin
         chk("ena drdy", 160'(drdy3), 160'(0));
         chk("ena rnd_rdy", 160'(rnd_rdy3), 160'(0));
         chk("ena ovld", 160'(ovld3), 160'(0));
         tick();
      end
      ena = 1; rnd3 = 32'h0F0F0F0F;
      #1;
      chk("ena resume rnd_rdy", 160'(rnd_rdy3), 160'(1));
      tick();
      rnd_vld3 = 0;
      chk("ena ovld late", 160'(ovld3), 160'(1));
      chk("ena o_x", 160'(ox3), 160'(96'hC396E798_0F0F0F0F_12345678));
      tick();

      // Reset in the middle of a split
      dvld3 = 1; ix3 = 32'hCAFEF00D;
      tick();
      dvld3 = 0; rnd3 = 32'h12345678; rnd_vld3 = 1;
      tick();
      rst = 1;
      tick();
      rst = 0; rnd_vld3 = 0;
      chk("rst ovld", 160'(ovld3), 160'(0));
      chk("rst o_x", 160'(ox3), 160'(0));
      chk("rst drdy", 160'(drdy3), 160'(1));
      run_op(32'hDEADBEEF, 32'h12345678, 32'h0F0F0F0F, 0,
             96'hC396E798_0F0F0F0F_12345678, "post-rst");

      // Randomized round trip on both instances
      for (int d = 0; d < 2; d++) begin
         mph[d] = 0; mk[d] = 0; ndone[d] = 0; mx[d] = '0;
      end
      for (int cyc = 0; cyc < 60000 && (ndone[0] < 1000 || ndone[1] < 1000); cyc++) begin
         for (int d = 0; d < 2; d++) begin
            int n;
            logic [2:0]   hs;
            logic [159:0] bus, expb;
            n    = (d == 0) ? 3 : 5;
            hs   = (d == 0) ? {drdy3, rnd_rdy3, ovld3} : {drdy5, rnd_rdy5, ovld5};
            bus  = (d == 0) ? {64'b0, ox3} : ox5;
            expb = (mph[d] == 2) ? model_bus(d, n) : '0;
            chk($sformatf("rand N%0d handshake", n), 160'(hs),
                160'({mph[d] == 0, mph[d] == 1, mph[d] == 2}));
            chk($sformatf("rand N%0d o_x", n), bus, expb);
            if (mph[d] == 2)
               chk($sformatf("rand N%0d unmask", n), 160'(unmask(bus, n)), 160'(mx[d]));
         end
         for (int d = 0; d < 2; d++) begin
            logic        dv, rv, orr;
            logic [31:0] x, r;
            int          n;
            n   = (d == 0) ? 3 : 5;
            dv  = ($urandom % 4) != 0;
            rv  = ($urandom % 3) != 0;
            orr = ($urandom % 3) != 0;
            x   = $urandom;
            r   = $urandom;
            if (d == 0) begin
               dvld3 = dv; ix3 = x; rnd_vld3 = rv; rnd3 = r; ordy3 = orr;
            end else begin
               dvld5 = dv; ix5 = x; rnd_vld5 = rv; rnd5 = r; ordy5 = orr;
            end
            if (mph[d] == 0 && dv) begin
               mph[d] = 1; mx[d] = x; mk[d] = 0;
            end else if (mph[d] == 1 && rv) begin
               mr[d][mk[d]] = r;
               mk[d]++;
               if (mk[d] == n-1) mph[d] = 2;
            end else if (mph[d] == 2 && orr) begin
               mph[d] = 0;
               ndone[d]++;
            end
         end
         tick();
      end
      checks++;
      if (ndone[0] < 1000 || ndone[1] < 1000) begin
         errs++;
         $display("FAIL rand timeout: completed N3=%0d N5=%0d required 1000 each", ndone[0], ndone[1]);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
